// File: rtl/qkv_mem_pkg.sv
// Shared constants and FSM encoding for the Q/K/V
// BRAM writer and its tile address generator.
package qkv_mem_pkg;

  localparam int COLS_WORDS   = 24;
  localparam int TILE_DIM     = 32;
  localparam int TILE_ROWS    = 16;
  localparam int MATRIX_WORDS = 12288;

  localparam int Q_BASE = 0;
  localparam int K_BASE = MATRIX_WORDS;
  localparam int V_BASE = 2 * MATRIX_WORDS;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STORE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/qkv_tile_addr_gen.sv
// Tile position and in-tile row counters; produces the
// region-relative word offset without a multiplier.
module qkv_tile_addr_gen
  import qkv_mem_pkg::*;
#(
  parameter int AW     = 16,
  parameter int CWORDS = COLS_WORDS,
  parameter int TDIM   = TILE_DIM,
  parameter int TROWS  = TILE_ROWS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  input  logic          beat,
  output logic [AW-1:0] offset,
  output logic          last_beat,
  output logic          last_tile
);

  localparam int CB = $clog2(CWORDS);
  localparam int RB = $clog2(TROWS);
  localparam int BB = $clog2(TDIM);

  localparam logic [AW-1:0] ROW_STEP  = AW'(CWORDS);
  localparam logic [AW-1:0] TILE_STEP = AW'(CWORDS * TDIM);

  logic [CB-1:0] tile_col;
  logic [RB-1:0] tile_row;
  logic [BB-1:0] r;
  logic [AW-1:0] row_base;
  logic [AW-1:0] trow_base;
  logic          col_last;
  logic          row_last;

  assign col_last  = tile_col == CB'(CWORDS - 1);
  assign row_last  = tile_row == RB'(TROWS - 1);
  assign last_beat = r == BB'(TDIM - 1);
  assign last_tile = col_last && row_last;
  assign offset    = row_base + AW'(tile_col);

  // trow_base remembers tile_row*TDIM*CWORDS so row_base
  // can rewind after a tile that stays in the same tile-row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_col  <= '0;
      tile_row  <= '0;
      r         <= '0;
      row_base  <= '0;
      trow_base <= '0;
    end else if (clr) begin
      tile_col  <= '0;
      tile_row  <= '0;
      r         <= '0;
      row_base  <= '0;
      trow_base <= '0;
    end else if (start) begin
      r        <= '0;
      row_base <= trow_base;
    end else if (beat) begin
      if (last_beat) begin
        r <= '0;
        if (col_last) begin
          tile_col <= '0;
          if (row_last) begin
            tile_row  <= '0;
            trow_base <= '0;
            row_base  <= '0;
          end else begin
            tile_row  <= tile_row + 1'b1;
            trow_base <= trow_base + TILE_STEP;
            row_base  <= trow_base + TILE_STEP;
          end
        end else begin
          tile_col <= tile_col + 1'b1;
          row_base <= trow_base;
        end
      end else begin
        r        <= r + 1'b1;
        row_base <= row_base + ROW_STEP;
      end
    end
  end

endmodule

// File: rtl/writeback_logic_gen.sv
// Port A writer for the Q/K/V BRAM: accepts result rows
// and places each 32x32 tile in row-major order.
module writeback_logic_gen
  import qkv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH       = 16,
  parameter int ORIGINAL_COLUMNS = 768,
  parameter int ORIGINAL_ROWS    = 512,
  parameter int NUM_BITS         = 8,
  parameter int DATA_WIDTH       = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic [2:0]            Buffer_Select,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  store_done,
  output logic                  matrix_done,
  output logic                  sel_err
);

  localparam int CW = ORIGINAL_COLUMNS * NUM_BITS / DATA_WIDTH;
  localparam int TR = ORIGINAL_ROWS / TILE_DIM;
  localparam int MW = ORIGINAL_ROWS * CW;

  wb_state_e             state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  last_beat;
  logic                  last_tile;
  logic                  sel_ok;
  logic                  go;
  logic                  beat;
  logic                  wr_q;

  assign in_ready = state == S_STORE;
  assign sel_ok   = Buffer_Select < 3'd3;
  assign go       = (state == S_IDLE) && start_store
                    && !reset_addr_counter;
  assign beat     = in_valid && in_ready && !reset_addr_counter;
  assign ena      = wr_q;
  assign wea      = wr_q;

  always_comb begin
    base_d = '0;
    unique case (1'b1)
      Buffer_Select == 3'd1: base_d = ADDR_WIDTH'(MW);
      Buffer_Select == 3'd2: base_d = ADDR_WIDTH'(2 * MW);
      default:               base_d = '0;
    endcase
  end

  qkv_tile_addr_gen #(
    .AW     (ADDR_WIDTH),
    .CWORDS (CW),
    .TDIM   (TILE_DIM),
    .TROWS  (TR)
  ) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (reset_addr_counter),
    .start     (go && sel_ok),
    .beat      (beat),
    .offset    (offset),
    .last_beat (last_beat),
    .last_tile (last_tile)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      sel_err     <= 1'b0;
      wr_q        <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      store_done  <= 1'b0;
      matrix_done <= 1'b0;
    end else begin
      wr_q        <= beat;
      store_done  <= beat && last_beat;
      matrix_done <= beat && last_beat && last_tile;
      if (beat) begin
        addra <= base_q + offset;
        dina  <= in_data;
      end
      if (reset_addr_counter) begin
        state   <= S_IDLE;
        sel_err <= 1'b0;
      end else if (go) begin
        if (sel_ok) begin
          state  <= S_STORE;
          base_q <= base_d;
        end else begin
          sel_err <= 1'b1;
        end
      end else if (beat && last_beat) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_writeback_logic_gen.sv
// Directed bench for writeback_logic_gen: tile table plus
// gap, abort, illegal-select and mid-tile start sequences.
module tb_writeback_logic_gen;

  localparam int AW = 16;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_store = 1'b0;
  logic          reset_addr_counter = 1'b0;
  logic [2:0]    Buffer_Select = 3'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          store_done;
  logic          matrix_done;
  logic          sel_err;

  int n_cmp = 0;
  int n_bad = 0;
  int sd_cnt = 0;
  int md_cnt = 0;
  int m_idx = 0;
  int t_first = -1;
  int t_last = -1;
  logic acc_q = 1'b0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  typedef struct {
    int sel;
    int ntiles;
    int first_exp;
    int last_exp;
    int md_exp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  writeback_logic_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_store        (start_store),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .ena                (ena),
    .wea                (wea),
    .addra              (addra),
    .dina               (dina),
    .store_done         (store_done),
    .matrix_done        (matrix_done),
    .sel_err            (sel_err)
  );

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(int sel, int idx, int b);
    return AW'(sel * 12288 + ((idx / 24) * 32 + b) * 24 + idx % 24);
  endfunction

  function automatic logic [DW-1:0] make_data(int idx, int b);
    logic [DW-1:0] d;
    d = '0;
    d[31:0]    = 32'(b);
    d[63:32]   = 32'(idx);
    d[255:248] = 8'hA5;
    return d;
  endfunction

  always @(posedge clk)
    acc_q <= rst_n && in_valid && in_ready && !reset_addr_counter;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ena_eq_wea", DW'(ena), DW'(wea));
      check("wea_vs_accept", DW'(wea), DW'(acc_q));
      if (wea) begin
        wq_addr.push_back(addra);
        wq_data.push_back(dina);
      end
      if (store_done) sd_cnt++;
      if (matrix_done) md_cnt++;
    end
  end

  task automatic do_tile(input int sel, input bit gaps,
                         input int abort_at, input int mid_at,
                         output int nb);
    int b;
    int cyc;
    int sd0;
    bit acc;
    b = 0;
    cyc = 0;
    sd0 = sd_cnt;
    Buffer_Select = 3'(sel);
    start_store = 1'b1;
    @(posedge clk); #1;
    start_store = 1'b0;
    while (b < 32 && b != abort_at && cyc < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = make_data(m_idx, b);
      start_store = (b == mid_at);
      if (b == mid_at) Buffer_Select = 3'd2;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) b++;
      cyc++;
    end
    in_valid = 1'b0;
    start_store = 1'b0;
    Buffer_Select = 3'(sel);
    @(posedge clk); #1;
    if (abort_at < 0) check("beats_accepted", DW'(b), DW'(32));
    check("write_count", DW'(wq_addr.size()), DW'(b));
    for (int i = 0; i < wq_addr.size() && i < b; i++) begin
      check($sformatf("addr_t%0d_b%0d", m_idx, i),
            DW'(wq_addr[i]), DW'(exp_addr(sel, m_idx, i)));
      check($sformatf("data_t%0d_b%0d", m_idx, i),
            wq_data[i], make_data(m_idx, i));
    end
    if (wq_addr.size() > 0) begin
      t_first = int'(wq_addr[0]);
      t_last = int'(wq_addr[wq_addr.size() - 1]);
    end
    check("store_done_cnt", DW'(sd_cnt - sd0), DW'(b == 32 ? 1 : 0));
    if (b == 32) m_idx = (m_idx + 1) % 384;
    wq_addr.delete();
    wq_data.delete();
    nb = b;
  endtask

  initial begin
    int nb;
    int md0;
    vecs[0] = '{0, 1, 0, 744, 0};
    vecs[1] = '{1, 1, 12289, 13033, 0};
    vecs[2] = '{1, 23, 13056, 13800, 0};
    vecs[3] = '{2, 359, 36119, 36863, 1};
    vecs[4] = '{2, 1, 24576, 25320, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_ena", DW'(ena), '0);
    check("rst_wea", DW'(wea), '0);
    check("rst_addra", DW'(addra), '0);
    check("rst_dina", dina, '0);
    check("rst_store_done", DW'(store_done), '0);
    check("rst_matrix_done", DW'(matrix_done), '0);
    check("rst_sel_err", DW'(sel_err), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      md0 = md_cnt;
      for (int k = 0; k < vecs[v].ntiles; k++)
        do_tile(vecs[v].sel, 1'b0, -1, -1, nb);
      check($sformatf("vec%0d_first", v), DW'(t_first),
            DW'(vecs[v].first_exp));
      check($sformatf("vec%0d_last", v), DW'(t_last),
            DW'(vecs[v].last_exp));
      check($sformatf("vec%0d_matrix_done", v), DW'(md_cnt - md0),
            DW'(vecs[v].md_exp));
    end

    // stalled tile: data still lands at the right addresses
    do_tile(0, 1'b1, -1, -1, nb);
    check("gap_first", DW'(t_first), DW'(1));
    check("gap_last", DW'(t_last), DW'(745));

    // abort mid-tile, then restart from the region base
    do_tile(1, 1'b0, 10, -1, nb);
    reset_addr_counter = 1'b1;
    @(posedge clk); #1;
    reset_addr_counter = 1'b0;
    check("abort_in_ready", DW'(in_ready), '0);
    m_idx = 0;
    do_tile(1, 1'b0, -1, -1, nb);
    check("after_abort_first", DW'(t_first), DW'(12288));

    // illegal select
    Buffer_Select = 3'd5;
    start_store = 1'b1;
    @(posedge clk); #1;
    start_store = 1'b0;
    check("bad_sel_err", DW'(sel_err), DW'(1));
    check("bad_sel_idle", DW'(in_ready), '0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_sel_no_write", DW'(wq_addr.size()), '0);
    check("bad_sel_sticky", DW'(sel_err), DW'(1));
    reset_addr_counter = 1'b1;
    start_store = 1'b1;
    Buffer_Select = 3'd0;
    @(posedge clk); #1;
    reset_addr_counter = 1'b0;
    start_store = 1'b0;
    check("clr_sel_err", DW'(sel_err), '0);
    check("clr_blocks_start", DW'(in_ready), '0);
    m_idx = 0;

    // start during STORE must not disturb the tile
    do_tile(0, 1'b0, -1, 5, nb);
    check("mid_start_first", DW'(t_first), DW'(0));
    do_tile(0, 1'b0, -1, -1, nb);
    check("mid_start_next", DW'(t_first), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
